// File: rtl/cam_stream_receiver_if.sv
// Packet output stream of the CAM receiver: head packet, its flags and the
// valid/ready handshake toward the consumer.
interface cam_stream_receiver_if;
  logic [31:0] pkt_o;
  logic        pkt_valid_o;
  logic        pkt_ready_i;
  logic        pkt_is_reset_o;
  logic        pkt_is_heartbeat_o;

  modport master (
    output pkt_o, pkt_valid_o, pkt_is_reset_o, pkt_is_heartbeat_o,
    input  pkt_ready_i
  );

  modport slave (
    input  pkt_o, pkt_valid_o, pkt_is_reset_o, pkt_is_heartbeat_o,
    output pkt_ready_i
  );
endinterface

// File: rtl/cam_stream_receiver.sv
// Receive side of the 4-bit CAM bus-capture stream. Synchronizes the strobe,
// sync and nibble lines, realigns nibbles into 32-bit packets, classifies
// reset/heartbeat packets and buffers them for a valid/ready consumer.
module cam_stream_receiver #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 4096,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  cam_pclk,
  input  logic                  cam_sync,
  input  logic [3:0]            cam_data,
  cam_stream_receiver_if.master pkt_if,
  output logic                  locked_o,
  output logic [15:0]           pkt_count_o,
  output logic [15:0]           resync_err_count_o,
  output logic [15:0]           drop_count_o,
  output logic [15:0]           hb_gap_count_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {S_HUNT, S_LOCKED} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------- synchronizers and sample event ----------------
  logic [SYNC_STAGES-1:0]      r_pclk_sync;
  logic [SYNC_STAGES-1:0]      r_sync_sync;
  logic [SYNC_STAGES-1:0][3:0] r_data_sync;
  logic                        r_pclk_d;
  logic                        r_evt;
  logic                        r_evt_sync;
  logic [3:0]                  r_evt_nib;

  logic       w_pclk_s;
  logic       w_sync_s;
  logic [3:0] w_data_s;

  // All three lines share one depth so the strobe and its payload stay aligned.
  assign w_pclk_s = r_pclk_sync[SYNC_STAGES-1];
  assign w_sync_s = r_sync_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

  // Synchronizer chains plus registered rising-edge detect of pclk.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_pclk_sync <= '0;
      r_sync_sync <= '0;
      r_data_sync <= '0;
      r_pclk_d    <= 1'b0;
      r_evt       <= 1'b0;
      r_evt_sync  <= 1'b0;
      r_evt_nib   <= 4'h0;
    end else begin
      r_pclk_sync <= {r_pclk_sync[SYNC_STAGES-2:0], cam_pclk};
      r_sync_sync <= {r_sync_sync[SYNC_STAGES-2:0], cam_sync};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], cam_data};
      r_pclk_d    <= w_pclk_s;
      r_evt       <= w_pclk_s & ~r_pclk_d;
      r_evt_sync  <= w_sync_s;
      r_evt_nib   <= w_data_s;
    end
  end

  // ---------------- alignment FSM ----------------
  state_t        r_state;
  logic [2:0]    r_idx;
  logic [31:0]   r_shreg;
  logic [IW-1:0] r_idle;
  logic [15:0]   r_resync_cnt;

  logic        w_locked;
  logic        w_resync;
  logic        w_complete;
  logic        w_timeout;
  logic [31:0] w_pkt;

  assign w_locked   = (r_state == S_LOCKED);
  assign w_resync   = r_evt & w_locked & r_evt_sync & (r_idx != 3'd0);
  assign w_complete = r_evt & w_locked & ~w_resync & (r_idx == 3'd7);
  assign w_timeout  = ~r_evt & w_locked & (r_idx != 3'd0) &
                      (r_idle == IW'(IDLE_TIMEOUT - 1));
  assign w_pkt      = {r_shreg[27:0], r_evt_nib};

  // Hunt for sync, then shift nibbles in; resync and idle abandon partials.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state      <= S_HUNT;
      r_idx        <= 3'd0;
      r_shreg      <= '0;
      r_idle       <= '0;
      r_resync_cnt <= '0;
    end else if (r_evt) begin
      r_idle  <= '0;
      // Older nibbles simply shift out, so a restart needs no explicit clear.
      r_shreg <= w_pkt;
      case (r_state)
        S_HUNT: begin
          if (r_evt_sync) begin
            r_state <= S_LOCKED;
            r_idx   <= 3'd1;
          end
        end
        default: begin
          if (w_resync) begin
            r_idx        <= 3'd1;
            r_resync_cnt <= sat_inc(r_resync_cnt);
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
      endcase
    end else if (w_locked && (r_idx != 3'd0)) begin
      if (w_timeout) begin
        r_state <= S_HUNT;
        r_idx   <= 3'd0;
        r_idle  <= '0;
      end else begin
        r_idle <= r_idle + IW'(1);
      end
    end else begin
      r_idle <= '0;
    end
  end

  // ---------------- output FIFO ----------------
  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop_full;

  assign w_full      = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop       = (r_cnt != '0) & pkt_if.pkt_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push      = w_complete & (~w_full | w_pop);
  assign w_drop_full = w_complete & w_full & ~w_pop;

  // Storage array, written on push only.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= w_pkt;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ---------------- heartbeat tracking and counters ----------------
  logic        r_hb_vld;
  logic [7:0]  r_last_hb;
  logic [15:0] r_hb_gap_cnt;
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_drop_cnt;

  logic w_new_is_hb;
  assign w_new_is_hb = (w_pkt[31:16] == 16'hC0FF) && (w_pkt[7:0] == 8'hAA);

  // Heartbeat continuity is judged on every completed packet, dropped or not.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_hb_vld     <= 1'b0;
      r_last_hb    <= 8'h00;
      r_hb_gap_cnt <= '0;
    end else if (w_complete) begin
      if (w_pkt == 32'h0000_0001) begin
        r_hb_vld <= 1'b0;
      end else if (w_new_is_hb) begin
        if (r_hb_vld && (w_pkt[15:8] != r_last_hb + 8'd1))
          r_hb_gap_cnt <= sat_inc(r_hb_gap_cnt);
        r_last_hb <= w_pkt[15:8];
        r_hb_vld  <= 1'b1;
      end
    end
  end

  // Written and dropped packet counters; full-drop and timeout never coincide.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_pkt_cnt <= sat_inc(r_pkt_cnt);
      if (w_drop_full || w_timeout) r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  // ---------------- outputs ----------------
  assign pkt_if.pkt_valid_o        = (r_cnt != '0);
  assign pkt_if.pkt_o              = pkt_if.pkt_valid_o ? r_mem[r_rd] : 32'h0;
  assign pkt_if.pkt_is_reset_o     = (pkt_if.pkt_o == 32'h0000_0001);
  assign pkt_if.pkt_is_heartbeat_o = (pkt_if.pkt_o[31:16] == 16'hC0FF) &&
                                     (pkt_if.pkt_o[7:0] == 8'hAA);
  assign locked_o           = w_locked;
  assign pkt_count_o        = r_pkt_cnt;
  assign resync_err_count_o = r_resync_cnt;
  assign drop_count_o       = r_drop_cnt;
  assign hb_gap_count_o     = r_hb_gap_cnt;

endmodule
